// File: rtl/display_timing_gen_pkg.sv
// display_timing_gen_pkg: raster mode types, default 640x480 mode and blanking-start helpers
package display_timing_gen_pkg;

    typedef struct packed {
        int res;
        int fp;
        int sync;
        int bp;
    } axis_mode_t;

    typedef struct packed {
        axis_mode_t h;
        axis_mode_t v;
    } video_mode_t;

    localparam video_mode_t MODE_640X480 = '{
        h: '{res: 640, fp: 16, sync: 96, bp: 48},
        v: '{res: 480, fp: 10, sync: 2,  bp: 33}
    };

    // Coordinates go negative through the blanking interval and hit 0 at the first active pixel
    function automatic int axis_sta(axis_mode_t m);
        return -(m.fp + m.sync + m.bp);
    endfunction

    function automatic int axis_sync_beg(axis_mode_t m);
        return axis_sta(m) + m.fp;
    endfunction

    function automatic int axis_sync_end(axis_mode_t m);
        return axis_sync_beg(m) + m.sync - 1;
    endfunction

endpackage

// File: rtl/display_timing_gen_if.sv
// display_timing_gen_if: raster timing bundle from the timing generator to the renderers
interface display_timing_gen_if #(
    parameter int CORDW = 16
);
    logic signed [CORDW-1:0] sx;
    logic signed [CORDW-1:0] sy;
    logic                    hsync;
    logic                    vsync;
    logic                    de;
    logic                    line;
    logic                    frame;

    modport master (output sx, sy, hsync, vsync, de, line, frame);
    modport slave  (input  sx, sy, hsync, vsync, de, line, frame);
endinterface

// File: rtl/display_timing_gen_timing_axis_counter.sv
// timing_axis_counter: one raster axis, STA..END wrapping counter with next-state sync decode
module timing_axis_counter #(
    parameter int CORDW    = 16,
    parameter int STA      = -160,
    parameter int END      = 639,
    parameter int SYNC_BEG = -144,
    parameter int SYNC_END = -49
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step_i,
    output logic signed [CORDW-1:0] coord_o,
    output logic signed [CORDW-1:0] next_o,
    output logic                    wrap_o,
    output logic                    sync_o
);
    localparam logic signed [CORDW-1:0] STA_C = CORDW'(STA);
    localparam logic signed [CORDW-1:0] END_C = CORDW'(END);
    localparam logic signed [CORDW-1:0] SB_C  = CORDW'(SYNC_BEG);
    localparam logic signed [CORDW-1:0] SE_C  = CORDW'(SYNC_END);
    localparam logic signed [CORDW-1:0] ONE   = CORDW'(1);

    logic signed [CORDW-1:0] coord_q, coord_d;

    always_comb begin
        wrap_o  = step_i && coord_q == END_C;
        coord_d = !step_i ? coord_q : wrap_o ? STA_C : coord_q + ONE;
        sync_o  = coord_d >= SB_C && coord_d <= SE_C;
    end

    // Resting at END makes the first enabled step land exactly on STA
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) coord_q <= END_C;
        else        coord_q <= coord_d;

    assign coord_o = coord_q;
    assign next_o  = coord_d;
endmodule

// File: rtl/display_timing_gen.sv
// display_timing_gen: registered raster timing (coordinates, syncs, data enable, line/frame strobes)
module display_timing_gen
    import display_timing_gen_pkg::*;
#(
    parameter int CORDW  = 16,
    parameter int H_RES  = MODE_640X480.h.res,
    parameter int H_FP   = MODE_640X480.h.fp,
    parameter int H_SYNC = MODE_640X480.h.sync,
    parameter int H_BP   = MODE_640X480.h.bp,
    parameter int V_RES  = MODE_640X480.v.res,
    parameter int V_FP   = MODE_640X480.v.fp,
    parameter int V_SYNC = MODE_640X480.v.sync,
    parameter int V_BP   = MODE_640X480.v.bp,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    display_timing_gen_if.master vid_o
);
    localparam axis_mode_t H_MODE = '{res: H_RES, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam axis_mode_t V_MODE = '{res: V_RES, fp: V_FP, sync: V_SYNC, bp: V_BP};

    logic signed [CORDW-1:0] sx, sy, sx_d, sy_d;
    logic h_wrap, v_wrap, h_sync, v_sync;
    logic hsync_q, vsync_q, de_q, line_q, frame_q;
    logic hsync_d, vsync_d, de_d, line_d, frame_d;

    timing_axis_counter #(
        .CORDW(CORDW), .STA(axis_sta(H_MODE)), .END(H_RES - 1),
        .SYNC_BEG(axis_sync_beg(H_MODE)), .SYNC_END(axis_sync_end(H_MODE))
    ) u_h (
        .clk(clk), .rst_n(rst_n), .step_i(1'b1),
        .coord_o(sx), .next_o(sx_d), .wrap_o(h_wrap), .sync_o(h_sync)
    );

    // Vertical axis advances only on the horizontal wrap, so both wrap on the same edge at end of frame
    timing_axis_counter #(
        .CORDW(CORDW), .STA(axis_sta(V_MODE)), .END(V_RES - 1),
        .SYNC_BEG(axis_sync_beg(V_MODE)), .SYNC_END(axis_sync_end(V_MODE))
    ) u_v (
        .clk(clk), .rst_n(rst_n), .step_i(h_wrap),
        .coord_o(sy), .next_o(sy_d), .wrap_o(v_wrap), .sync_o(v_sync)
    );

    always_comb begin
        hsync_d = h_sync ? H_POL : ~H_POL;
        vsync_d = v_sync ? V_POL : ~V_POL;
        de_d    = ~sx_d[CORDW-1] & ~sy_d[CORDW-1];
        line_d  = h_wrap;
        frame_d = h_wrap & v_wrap;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end

    assign vid_o.sx    = sx;
    assign vid_o.sy    = sy;
    assign vid_o.hsync = hsync_q;
    assign vid_o.vsync = vsync_q;
    assign vid_o.de    = de_q;
    assign vid_o.line  = line_q;
    assign vid_o.frame = frame_q;
endmodule

// File: tb/tb_display_timing_gen.sv
// tb_display_timing_gen: default-mode and small-mode timing checks with a per-cycle scoreboard
module tb_display_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_timing_gen_if #(.CORDW(16)) if_d ();
    display_timing_gen_if #(.CORDW(16)) if_s ();
    display_timing_gen_if #(.CORDW(16)) if_p ();

    display_timing_gen dut_d (.clk(clk), .rst_n(rst_n), .vid_o(if_d));

    // Small mode: H 16/2/3/4 (STA -9, hsync -7..-5), V 8/1/2/3 (STA -6, vsync -5..-4)
    display_timing_gen #(
        .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_RES(8),  .V_FP(1), .V_SYNC(2), .V_BP(3)
    ) dut_s (.clk(clk), .rst_n(rst_n), .vid_o(if_s));

    display_timing_gen #(
        .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_RES(8),  .V_FP(1), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_p (.clk(clk), .rst_n(rst_n), .vid_o(if_p));

    typedef struct packed {
        logic signed [15:0] sx;
        logic signed [15:0] sy;
        logic hs;
        logic vs;
        logic de;
        logic ln;
        logic fr;
    } exp_t;

    localparam logic [36:0] POL_MASK = 37'b11000;

    exp_t exp_q[$];
    int checks = 0;
    int fails  = 0;
    int m_sx, m_sy;

    function automatic exp_t mk(int x, int y, bit ln, bit fr);
        exp_t e;
        e.sx = 16'(x);
        e.sy = 16'(y);
        e.hs = (x >= -7 && x <= -5) ? 1'b0 : 1'b1;
        e.vs = (y >= -5 && y <= -4) ? 1'b0 : 1'b1;
        e.de = (x >= 0 && y >= 0);
        e.ln = ln;
        e.fr = fr;
        return e;
    endfunction

    function automatic exp_t rst_exp();
        exp_t e;
        e = mk(15, 7, 1'b0, 1'b0);
        e.de = 1'b0;
        return e;
    endfunction

    function automatic exp_t obs_s();
        return {if_s.sx, if_s.sy, if_s.hsync, if_s.vsync, if_s.de, if_s.line, if_s.frame};
    endfunction

    function automatic exp_t obs_p();
        return {if_p.sx, if_p.sy, if_p.hsync, if_p.vsync, if_p.de, if_p.line, if_p.frame};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        m_sx = 15;
        m_sy = 7;
        exp_q.delete();
    endtask

    // Model advances and pushes the expected outputs, then the DUT edge is taken and popped against
    task automatic tick();
        exp_t e;
        if (m_sx == 15) begin
            m_sx = -9;
            m_sy = (m_sy == 7) ? -6 : m_sy + 1;
            e = mk(m_sx, m_sy, 1'b1, m_sy == -6);
        end else begin
            m_sx++;
            e = mk(m_sx, m_sy, 1'b0, 1'b0);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("scoreboard", obs_s(), e);
        chk("polarity", obs_p(), e ^ POL_MASK);
    endtask

    initial begin
        int n, lows, first_low, last_low, des, lines, vlows, vmin, vmax, neg_de;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_small", obs_s(), rst_exp());
        chk("rst_pol", obs_p(), rst_exp() ^ POL_MASK);
        chk("rst_d_sx", if_d.sx, 639);
        chk("rst_d_sy", if_d.sy, 479);
        chk("rst_d_flags", {if_d.hsync, if_d.vsync, if_d.de, if_d.line, if_d.frame}, 5'b11000);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("first_sx", if_d.sx, -160);
        chk("first_sy", if_d.sy, -45);
        chk("first_strobes", {if_d.line, if_d.frame}, 2'b11);
        tick();
        chk("second_strobes", {if_d.line, if_d.frame}, 2'b00);

        n = 1; lows = 0; first_low = 9999; last_low = 9999; des = 0;
        while (!if_d.line && n < 2000) begin
            if (!if_d.hsync) begin
                lows++;
                if (first_low == 9999) first_low = if_d.sx;
                last_low = if_d.sx;
            end
            des += int'(if_d.de);
            tick();
            n++;
        end
        chk("line_period", n, 800);
        chk("hsync_cycles", lows, 96);
        chk("hsync_first", first_low, -144);
        chk("hsync_last", last_low, -49);
        chk("blank_line_de", des, 0);

        n = 0;
        while (!if_s.frame && n < 1000) begin
            tick();
            n++;
        end
        chk("small_frame_seen", if_s.frame, 1'b1);
        n = 0; des = 0; lines = 0; vlows = 0; vmin = 99; vmax = -99; neg_de = 0;
        do begin
            des   += int'(if_s.de);
            lines += int'(if_s.line);
            if (!if_s.vsync) begin
                vlows++;
                if (if_s.sy < vmin) vmin = if_s.sy;
                if (if_s.sy > vmax) vmax = if_s.sy;
            end
            if (if_s.sy < 0) neg_de += int'(if_s.de);
            tick();
            n++;
        end while (!if_s.frame && n < 1000);
        chk("frame_period", n, 350);
        chk("frame_de", des, 128);
        chk("frame_lines", lines, 14);
        chk("vsync_cycles", vlows, 50);
        chk("vsync_min_sy", vmin, -5);
        chk("vsync_max_sy", vmax, -4);
        chk("blank_de", neg_de, 0);

        n = 0;
        while (!(if_d.line && if_d.sy == 0) && n < 40000) begin
            tick();
            n++;
        end
        chk("active_line_seen", {if_d.line, if_d.sy}, {1'b1, 16'sd0});
        n = 0; des = 0;
        do begin
            des += int'(if_d.de);
            tick();
            n++;
        end while (n < 800);
        chk("active_line_de", des, 640);

        n = 0;
        while (!(if_s.sx == 10 && if_s.sy == 5) && n < 400) begin
            tick();
            n++;
        end
        chk("mid_point_seen", {if_s.sx, if_s.sy}, {16'sd10, 16'sd5});
        rst_n = 1'b0;
        #1;
        reset_model();
        chk("rst_mid_small", obs_s(), rst_exp());
        chk("rst_mid_pol", obs_p(), rst_exp() ^ POL_MASK);
        chk("rst_mid_d", {if_d.sx, if_d.sy, if_d.de, if_d.line, if_d.frame}, {16'sd639, 16'sd479, 3'b000});
        @(posedge clk);
        #1;
        chk("rst_hold_small", obs_s(), rst_exp());
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("restart_d", {if_d.sx, if_d.sy, if_d.frame}, {-16'sd160, -16'sd45, 1'b1});
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
